mmu_axi_read_arb: RTL and testbench

MMU_AXI_READ_ARB -- requirements
Module: mmu_axi_read_arb

---
 rtl/mmu_pkg.sv | 14 +
 rtl/mmu_rr_arbiter.sv | 46 ++++
 rtl/mmu_axi_read_arb.sv | 148 ++++++++++++++
 tb/tb_mmu_axi_read_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and AXI encodings for the MMU read-path arbiter.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

endpackage

// File: rtl/mmu_rr_arbiter.sv
// Combinational request arbiter: round-robin from a pointer, or fixed
// priority with port 0 highest. The pointer register lives in the parent.
module mmu_rr_arbiter #(
    parameter int NPORT   = 2,
    parameter int RR_MODE = 1,
    parameter int IW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [NPORT-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk the ports starting at the pointer (or at 0) and take the first requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (RR_MODE != 0) begin
                sum = {1'b0, ptr} + (IW+1)'(i);
                if (sum >= (IW+1)'(NPORT)) begin
                    sum = sum - (IW+1)'(NPORT);
                end
                cand = sum[IW-1:0];
            end else begin
                cand = IW'(i);
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mmu_axi_read_arb.sv
// Arbitrates NPORT read requesters onto one AXI read port, one transaction
// in flight, and steers returning beats back to the granted requester.
module mmu_axi_read_arb
    import mmu_pkg::*;
#(
    parameter int NPORT     = 2,
    parameter int BURST_LEN = 16,
    parameter int RR_MODE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORT-1:0]     req_valid,
    input  logic [32*NPORT-1:0]  req_addr,
    input  logic [NPORT-1:0]     req_single,
    output logic [NPORT-1:0]     req_ready,
    output logic [31:0]          resp_data,
    output logic [NPORT-1:0]     resp_valid,
    output logic [NPORT-1:0]     resp_last,
    output logic [NPORT-1:0]     resp_err,
    output logic [3:0]           arid,
    output logic [31:0]          araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [3:0]           rid,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   grant_q;
    logic [31:0]     addr_q;
    logic [7:0]      len_q;
    logic [1:0]      burst_q;
    logic            arvalid_q;

    logic [NPORT-1:0] arb_grant;
    logic [IW-1:0]    win_idx;
    logic             arb_any;
    logic [31:0]      sel_addr;
    logic             sel_single;
    logic             beat_hit;

    mmu_rr_arbiter #(
        .NPORT   (NPORT),
        .RR_MODE (RR_MODE),
        .IW      (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (win_idx),
        .any       (arb_any)
    );

    // Pick the winner's address and mode by OR-ing through the one-hot grant
    always_comb begin
        sel_addr   = '0;
        sel_single = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (arb_grant[k]) begin
                sel_addr   = sel_addr | req_addr[32*k +: 32];
                sel_single = sel_single | req_single[k];
            end
        end
    end

    assign beat_hit = (state == DATA) && rvalid && (rid == 4'(grant_q));

    // Transaction FSM: latch winner, present address, wait for the last matching beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            arvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_q   <= win_idx;
                        addr_q    <= sel_addr;
                        arvalid_q <= 1'b1;
                        state     <= ADDR;
                        if (sel_single) begin
                            len_q   <= 8'd0;
                            burst_q <= AXI_BURST_FIXED;
                        end else begin
                            len_q   <= 8'(BURST_LEN - 1);
                            burst_q <= AXI_BURST_INCR;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat_hit && rlast) begin
                        state <= IDLE;
                        ptr   <= (grant_q == IW'(NPORT - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Steer the acceptance pulse and matching read beats to the granted port only
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_last  = '0;
        resp_err   = '0;
        resp_data  = '0;
        if (arvalid_q && arready) begin
            req_ready[grant_q] = 1'b1;
        end
        if (beat_hit) begin
            resp_valid[grant_q] = 1'b1;
            resp_data           = rdata;
            resp_last[grant_q]  = rlast;
            resp_err[grant_q]   = (rresp != 2'b00);
        end
    end

    assign arid    = 4'(grant_q);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = burst_q;
    assign arvalid = arvalid_q;
    assign rready  = 1'b1;

endmodule

// File: tb/tb_mmu_axi_read_arb.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share the same
// stimulus; sel chooses whose outputs are observed and checked.
module tb_mmu_axi_read_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_single;
    logic [63:0] req_addr;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        sel;

    logic [1:0][1:0]  req_ready_d, resp_valid_d, resp_last_d, resp_err_d, arburst_d;
    logic [1:0][31:0] resp_data_d, araddr_d;
    logic [1:0][3:0]  arid_d;
    logic [1:0][7:0]  arlen_d;
    logic [1:0][2:0]  arsize_d;
    logic [1:0]       arvalid_d, rready_d;

    logic [1:0]  req_ready_v, resp_valid_v, resp_last_v, resp_err_v, arburst_v;
    logic [31:0] resp_data_v, araddr_v;
    logic [3:0]  arid_v;
    logic [7:0]  arlen_v;
    logic [2:0]  arsize_v;
    logic        arvalid_v, rready_v;

    assign req_ready_v  = req_ready_d[sel];
    assign resp_valid_v = resp_valid_d[sel];
    assign resp_last_v  = resp_last_d[sel];
    assign resp_err_v   = resp_err_d[sel];
    assign resp_data_v  = resp_data_d[sel];
    assign arburst_v    = arburst_d[sel];
    assign araddr_v     = araddr_d[sel];
    assign arid_v       = arid_d[sel];
    assign arlen_v      = arlen_d[sel];
    assign arsize_v     = arsize_d[sel];
    assign arvalid_v    = arvalid_d[sel];
    assign rready_v     = rready_d[sel];

    mmu_axi_read_arb #(.NPORT(2), .BURST_LEN(16), .RR_MODE(1)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_single(req_single),
        .req_ready(req_ready_d[0]), .resp_data(resp_data_d[0]),
        .resp_valid(resp_valid_d[0]), .resp_last(resp_last_d[0]), .resp_err(resp_err_d[0]),
        .arid(arid_d[0]), .araddr(araddr_d[0]), .arlen(arlen_d[0]), .arsize(arsize_d[0]),
        .arburst(arburst_d[0]), .arvalid(arvalid_d[0]), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready_d[0])
    );

    mmu_axi_read_arb #(.NPORT(2), .BURST_LEN(16), .RR_MODE(0)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_single(req_single),
        .req_ready(req_ready_d[1]), .resp_data(resp_data_d[1]),
        .resp_valid(resp_valid_d[1]), .resp_last(resp_last_d[1]), .resp_err(resp_err_d[1]),
        .arid(arid_d[1]), .araddr(araddr_d[1]), .arlen(arlen_d[1]), .arsize(arsize_d[1]),
        .arburst(arburst_d[1]), .arvalid(arvalid_d[1]), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready_d[1])
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    beat_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    pulses0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Pop one expected beat per observed beat; with no beat, outputs must be quiet
    always @(negedge clk) begin
        beat_t      e;
        logic [1:0] oh;
        if (resp_valid_v != 2'b00) begin
            if (resp_valid_v[0]) pulses0++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 32'(resp_valid_v), 32'h0);
            end else begin
                e  = expQ.pop_front();
                oh = 2'b01 << e.port;
                checkOutput("beat_valid", 32'(resp_valid_v), 32'(oh));
                checkOutput("beat_data", resp_data_v, e.data);
                checkOutput("beat_last", 32'(resp_last_v), e.last ? 32'(oh) : 32'h0);
                checkOutput("beat_err", 32'(resp_err_v), e.err ? 32'(oh) : 32'h0);
            end
        end else begin
            checkOutput("idle_data", resp_data_v, 32'h0);
            checkOutput("idle_last", 32'(resp_last_v), 32'h0);
            checkOutput("idle_err", 32'(resp_err_v), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] single,
                                 input logic [31:0] a0, input logic [31:0] a1);
        @(posedge clk); #1;
        req_valid  = valid;
        req_single = single;
        req_addr   = {a1, a0};
        @(negedge clk);
    endtask

    task automatic idleStep();
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0;
        @(negedge clk);
    endtask

    task automatic driveBeat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                             input logic last, input int port);
        beat_t b;
        @(posedge clk); #1;
        rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last;
        if (port >= 0) begin
            b.port = 2'(port); b.data = data; b.last = last; b.err = (resp != 2'b00);
            expQ.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic burst(input int port, input int n, input logic stall, input int errIdx,
                         input logic [31:0] base, input int injectAt);
        for (int i = 0; i < n; i++) begin
            if (i == injectAt) driveBeat(4'd3, 32'hDEAD_0000, 2'b00, 1'b1, -1);
            driveBeat(4'(port), base + 32'(i), (i == errIdx) ? 2'b10 : 2'b00, (i == n - 1), port);
            if (stall) idleStep();
        end
        if (!stall) idleStep();
    endtask

    // Wait (bounded) for arvalid, check the address beat, hold off arready, then accept
    task automatic serveAr(input int port, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burstType, input int delay, input logic [1:0] drop);
        int waited;
        waited = 0;
        while (arvalid_v !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checkOutput("ar_latency", 32'(waited), 32'd1);
        checkOutput("arid", 32'(arid_v), 32'(port));
        checkOutput("araddr", araddr_v, addr);
        checkOutput("arlen", 32'(arlen_v), 32'(len));
        checkOutput("arburst", 32'(arburst_v), 32'(burstType));
        checkOutput("arsize", 32'(arsize_v), 32'h2);
        for (int i = 0; i < delay; i++) begin
            step();
            checkOutput("ar_hold_valid", 32'(arvalid_v), 32'h1);
            checkOutput("ar_hold_addr", araddr_v, addr);
            checkOutput("ar_no_ready", 32'(req_ready_v), 32'h0);
        end
        @(posedge clk); #1;
        arready = 1'b1;
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready_v), 32'(2'b01 << port));
        @(posedge clk); #1;
        arready   = 1'b0;
        req_valid = req_valid & ~drop;
        @(negedge clk);
        checkOutput("req_ready_pulse", 32'(req_ready_v), 32'h0);
        checkOutput("ar_dropped", 32'(arvalid_v), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base;
        rst = 1'b1; sel = 1'b0;
        req_valid = '0; req_single = '0; req_addr = '0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_arvalid", 32'(arvalid_v), 32'h0);
        checkOutput("rst_araddr", araddr_v, 32'h0);
        checkOutput("rst_arlen", 32'(arlen_v), 32'h0);
        checkOutput("rst_arburst", 32'(arburst_v), 32'h0);
        checkOutput("rst_arid", 32'(arid_v), 32'h0);
        checkOutput("rst_arsize", 32'(arsize_v), 32'h2);
        checkOutput("rst_rready", 32'(rready_v), 32'h1);
        checkOutput("rst_req_ready", 32'(req_ready_v), 32'h0);
        checkOutput("rst_resp_valid", 32'(resp_valid_v), 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);

        $display("[TB] round-robin alternation");
        applyStimulus(2'b11, 2'b11, 32'h0000_1000, 32'h0000_2000);
        for (int t = 0; t < 4; t++) begin
            serveAr(t % 2, (t % 2) ? 32'h0000_2000 : 32'h0000_1000, 8'd0, 2'b00, 0,
                    (t == 3) ? 2'b11 : 2'b00);
            driveBeat(4'(t % 2), 32'h100 + 32'(t), 2'b00, 1'b1, t % 2);
            idleStep();
            checkOutput("rr_gap", 32'(arvalid_v), 32'h0);
        end

        $display("[TB] stray beat and port 1 single read");
        driveBeat(4'd1, 32'h0000_0BAD, 2'b00, 1'b1, -1);
        idleStep();
        applyStimulus(2'b10, 2'b10, 32'h0, 32'h1FC0_0000);
        serveAr(1, 32'h1FC0_0000, 8'd0, 2'b00, 2, 2'b10);
        driveBeat(4'd1, 32'hCAFE_0001, 2'b00, 1'b1, 1);
        idleStep();

        $display("[TB] port 0 burst with stalls");
        base = pulses0;
        applyStimulus(2'b01, 2'b00, 32'h8000_0000, 32'h0);
        serveAr(0, 32'h8000_0000, 8'd15, 2'b01, 0, 2'b01);
        burst(0, 16, 1'b1, -1, 32'hA000_0000, -1);
        checkOutput("burst_pulses", 32'(pulses0 - base), 32'd16);
        checkOutput("burst_idle", 32'(arvalid_v), 32'h0);

        $display("[TB] foreign rid injected mid-burst");
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h4000_0040);
        serveAr(1, 32'h4000_0040, 8'd15, 2'b01, 0, 2'b10);
        burst(1, 16, 1'b0, -1, 32'hB000_0000, 3);

        $display("[TB] reset during burst");
        applyStimulus(2'b01, 2'b00, 32'h5000_0000, 32'h0);
        serveAr(0, 32'h5000_0000, 8'd15, 2'b01, 0, 2'b01);
        for (int i = 0; i < 4; i++) driveBeat(4'd0, 32'h5500_0000 + 32'(i), 2'b00, 1'b0, 0);
        @(posedge clk); #1;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h5500_0004; rresp = 2'b00; rlast = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_resp_valid", 32'(resp_valid_v), 32'h0);
        checkOutput("mid_rst_resp_data", resp_data_v, 32'h0);
        checkOutput("mid_rst_arlen", 32'(arlen_v), 32'h0);
        checkOutput("mid_rst_arburst", 32'(arburst_v), 32'h0);
        checkOutput("mid_rst_araddr", araddr_v, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        for (int i = 5; i < 16; i++) driveBeat(4'd0, 32'h5500_0000 + 32'(i), 2'b00, (i == 15), -1);
        idleStep();
        checkOutput("post_rst_idle", 32'(arvalid_v), 32'h0);

        $display("[TB] fixed priority with error beat");
        sel = 1'b1;
        applyStimulus(2'b11, 2'b10, 32'h6000_0000, 32'h7000_0000);
        serveAr(0, 32'h6000_0000, 8'd15, 2'b01, 0, 2'b00);
        burst(0, 16, 1'b0, 1, 32'hC000_0000, -1);
        serveAr(0, 32'h6000_0000, 8'd15, 2'b01, 0, 2'b01);
        burst(0, 16, 1'b0, -1, 32'hD000_0000, -1);
        serveAr(1, 32'h7000_0000, 8'd0, 2'b00, 0, 2'b10);
        driveBeat(4'd1, 32'hE000_0001, 2'b00, 1'b1, 1);
        idleStep();

        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
